// File: rtl/or_unit_arbiter.sv
// Round-robin arbiter in front of one shared, registered bitwise OR unit.
// One operation is in flight at a time: a requester is granted, its operands
// are latched, the OR is registered, and the result is held with the
// requester ID until the consumer accepts it.
module or_unit_arbiter #(
    parameter int unsigned NREQ = 4,
    parameter int unsigned DW   = 1,
    parameter int unsigned IDW  = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [NREQ-1:0]    req,
    input  logic [NREQ*DW-1:0] a_bus,
    input  logic [NREQ*DW-1:0] b_bus,
    output logic [NREQ-1:0]    gnt,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [DW-1:0]      rsp_data,
    output logic [IDW-1:0]     rsp_id,
    output logic              busy
);

    typedef enum logic [1:0] {StIdle, StIssue, StResp} state_e;

    state_e           state_q, state_d;
    logic [IDW-1:0]   ptr_q;
    logic [NREQ-1:0]  gnt_q;
    logic             rsp_valid_q;
    logic [DW-1:0]    rsp_data_q;
    logic [IDW-1:0]   rsp_id_q;
    logic [DW-1:0]    op_a_q, op_b_q;

    logic             win_found;
    logic [IDW-1:0]   win_id;
    logic [IDW-1:0]   ptr_nxt;
    logic [NREQ-1:0]  win_onehot;
    logic [DW-1:0]    win_a, win_b;
    logic [31:0]      ptr_ext;

    assign ptr_ext = 32'(ptr_q);

    // Winner search: first pass covers ptr..NREQ-1, second pass wraps to 0..ptr-1.
    always_comb begin
        win_found  = 1'b0;
        win_id     = '0;
        ptr_nxt    = ptr_q;
        win_onehot = '0;
        win_a      = '0;
        win_b      = '0;
        for (int unsigned p = 0; p < 2; p++) begin
            for (int unsigned i = 0; i < NREQ; i++) begin
                if (!win_found && req[i] && ((p == 0) ? (i >= ptr_ext) : (i < ptr_ext))) begin
                    win_found     = 1'b1;
                    win_id        = IDW'(i);
                    ptr_nxt       = (i == NREQ - 1) ? '0 : IDW'(i + 1);
                    win_onehot[i] = 1'b1;
                    win_a         = a_bus[i*DW +: DW];
                    win_b         = b_bus[i*DW +: DW];
                end
            end
        end
    end

    // State register.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic: ISSUE always lasts exactly one cycle.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle:  if (win_found) state_d = StIssue;
            StIssue: state_d = StResp;
            StResp:  if (rsp_ready) state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    // Output logic derived from state alone.
    always_comb begin
        busy = (state_q != StIdle);
    end

    // Datapath and registered outputs; reset drops any held result.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            ptr_q       <= '0;
            gnt_q       <= '0;
            rsp_valid_q <= 1'b0;
            rsp_data_q  <= '0;
            rsp_id_q    <= '0;
            op_a_q      <= '0;
            op_b_q      <= '0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (win_found) begin
                        gnt_q    <= win_onehot;
                        op_a_q   <= win_a;
                        op_b_q   <= win_b;
                        rsp_id_q <= win_id;
                        ptr_q    <= ptr_nxt;
                    end
                end
                StIssue: begin
                    gnt_q       <= '0;
                    rsp_data_q  <= op_a_q | op_b_q;
                    rsp_valid_q <= 1'b1;
                end
                StResp: begin
                    if (rsp_ready) rsp_valid_q <= 1'b0;
                end
                default: begin
                    gnt_q       <= '0;
                    rsp_valid_q <= 1'b0;
                end
            endcase
        end
    end

    assign gnt       = gnt_q;
    assign rsp_valid = rsp_valid_q;
    assign rsp_data  = rsp_data_q;
    assign rsp_id    = rsp_id_q;

endmodule

// File: tb/tb_or_unit_arbiter.sv
// Bench for or_unit_arbiter (NREQ=4, DW=4): directed scenarios followed by
// randomized requesters, all checked against a transaction-level model.
module tb_or_unit_arbiter;

    localparam int NREQ = 4;
    localparam int DW   = 4;
    localparam int IDW  = 2;

    logic              clk = 1'b0;
    logic              rst_n;
    logic [NREQ-1:0]    req;
    logic [NREQ*DW-1:0] a_bus, b_bus;
    logic [NREQ-1:0]    gnt;
    logic              rsp_valid;
    logic              rsp_ready;
    logic [DW-1:0]      rsp_data;
    logic [IDW-1:0]     rsp_id;
    logic              busy;

    or_unit_arbiter #(.NREQ(NREQ), .DW(DW), .IDW(IDW)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req       (req),
        .a_bus     (a_bus),
        .b_bus     (b_bus),
        .gnt       (gnt),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_data  (rsp_data),
        .rsp_id    (rsp_id),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    int n_vec  = 0;
    int n_fail = 0;

    // Model: a single in-flight transaction with an age counted in edges.
    int              rr;
    bit              live;
    int              age;
    logic [DW-1:0]   txn_data;
    logic [NREQ-1:0] e_gnt;
    logic            e_valid;
    logic [DW-1:0]   e_data;
    logic [IDW-1:0]  e_id;

    logic [NREQ-1:0] gq[$];

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic model_edge();
        logic [NREQ-1:0]    rq;
        logic [NREQ*DW-1:0] sa, sb;
        if (!rst_n) begin
            rr = 0; live = 0; age = 0;
            e_gnt = '0; e_valid = 1'b0; e_data = '0; e_id = '0;
        end else begin
            e_gnt = '0;
            if (!live) begin
                for (int k = 0; k < NREQ; k++) begin
                    int w;
                    w  = (rr + k) % NREQ;
                    rq = req >> w;
                    if (rq[0]) begin
                        sa       = a_bus >> (w * DW);
                        sb       = b_bus >> (w * DW);
                        live     = 1;
                        age      = 0;
                        e_gnt    = NREQ'(1 << w);
                        e_id     = IDW'(w);
                        txn_data = sa[DW-1:0] | sb[DW-1:0];
                        rr       = (w + 1) % NREQ;
                        break;
                    end
                end
            end else if (age == 0) begin
                e_valid = 1'b1;
                e_data  = txn_data;
                age     = 1;
            end else if (rsp_ready) begin
                e_valid = 1'b0;
                live    = 0;
            end
        end
    endtask

    // One clock: model follows the edge, outputs compared mid-cycle.
    task automatic step();
        @(posedge clk);
        model_edge();
        @(negedge clk);
        check_val("gnt",       32'(gnt),       32'(e_gnt));
        check_val("rsp_valid", 32'(rsp_valid), 32'(e_valid));
        check_val("rsp_data",  32'(rsp_data),  32'(e_data));
        check_val("rsp_id",    32'(rsp_id),    32'(e_id));
        check_val("busy",      32'(busy),      32'(live));
        if (gnt != '0) gq.push_back(gnt);
    endtask

    task automatic set_op(input int i, input logic [DW-1:0] a, input logic [DW-1:0] b);
        a_bus[i*DW +: DW] = a;
        b_bus[i*DW +: DW] = b;
    endtask

    // Requesters obey the protocol: hold until granted, then drop or issue anew.
    task automatic rand_stim();
        for (int i = 0; i < NREQ; i++) begin
            if (e_gnt[i]) begin
                req[i] = ($urandom_range(0, 3) == 0);
                set_op(i, DW'($urandom), DW'($urandom));
            end else if (!req[i]) begin
                set_op(i, DW'($urandom), DW'($urandom));
                if ($urandom_range(0, 2) == 0) req[i] = 1'b1;
            end
        end
        rsp_ready = 1'($urandom);
        rst_n     = ($urandom_range(0, 63) != 0);
    endtask

    logic [NREQ-1:0] exp_order [5];

    initial begin
        exp_order = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
        rst_n = 1'b0;
        req = NREQ'($urandom);
        a_bus = $urandom; b_bus = $urandom;
        rsp_ready = 1'b0;
        step();
        req = NREQ'($urandom);
        step();

        // Single request from requester 2.
        rst_n = 1'b1; rsp_ready = 1'b1;
        req = 4'b0100; set_op(2, 4'b0101, 4'b0011);
        step();
        check_val("single_gnt", 32'(gnt), 32'h4);
        req = 4'b0000;
        step();
        check_val("single_valid", 32'(rsp_valid), 32'h1);
        check_val("single_data", 32'(rsp_data), 32'h7);
        check_val("single_id", 32'(rsp_id), 32'h2);
        step();
        check_val("single_pulse", 32'(rsp_valid), 32'h0);

        // Pointer now at 3: requester 3 wins over 0.
        req = 4'b1001;
        step();
        check_val("wrap_gnt3", 32'(gnt), 32'h8);
        req = 4'b0001;
        step(); step(); step();
        check_val("wrap_gnt0", 32'(gnt), 32'h1);
        req = 4'b0000;
        step(); step();

        // Backpressure with a new request arriving during RESP.
        rsp_ready = 1'b0;
        req = 4'b0001; set_op(0, 4'b1010, 4'b0100);
        step();
        req = 4'b0000;
        step();
        for (int c = 0; c < 5; c++) begin
            if (c == 1) begin
                req = 4'b0010; set_op(1, 4'b0001, 4'b0010);
            end
            step();
            check_val("bp_hold_data", 32'(rsp_data), 32'hE);
        end
        rsp_ready = 1'b1;
        step();
        check_val("bp_no_early_gnt", 32'(gnt), 32'h0);
        step();
        check_val("bp_late_gnt", 32'(gnt), 32'h2);
        req = 4'b0000;
        step(); step();

        // Operand latch: change of a0 after grant is ignored.
        req = 4'b0001; set_op(0, 4'b0001, 4'b0000);
        step();
        req = 4'b0000; set_op(0, 4'b1000, 4'b0000);
        step();
        check_val("latch_data", 32'(rsp_data), 32'h1);
        step();

        // Reset while holding a response.
        rsp_ready = 1'b0;
        req = 4'b0100;
        step();
        req = 4'b0000;
        step(); step();
        rst_n = 1'b0;
        step();
        check_val("midrst_valid", 32'(rsp_valid), 32'h0);
        check_val("midrst_busy", 32'(busy), 32'h0);

        // Fair rotation with everyone requesting continuously.
        rst_n = 1'b1; rsp_ready = 1'b1; req = 4'b1111;
        gq.delete();
        for (int c = 0; c < 13; c++) step();
        check_val("rr_count_ge5", 32'(gq.size() >= 5), 32'h1);
        for (int k = 0; k < 5; k++) begin
            if (k < gq.size()) check_val("rr_order", 32'(gq[k]), 32'(exp_order[k]));
        end

        // Randomized traffic.
        for (int c = 0; c < 3000; c++) begin
            rand_stim();
            step();
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule
